// File: rtl/axis_pkg.sv
// Shared AXI-Stream definitions: checksum FSM state encoding, default width
// and the valid/ready handshake helper.
package axis_pkg;

    typedef enum logic {
        ST_PASS = 1'b0,
        ST_CSUM = 1'b1
    } csum_state_e;

    localparam int CSUM_W_DEFAULT = 8;

    function automatic logic fire(input logic valid, input logic ready);
        return valid & ready;
    endfunction

endpackage

// File: rtl/axis_out_reg.sv
// Single-entry AXI-Stream output register. It takes a new beat whenever it is
// free (empty, or its current beat is leaving) and holds its payload while stalled.
module axis_out_reg #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic         keep_i,
    input  logic         last_i,
    input  logic         ready_i,
    output logic         free_o,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    output logic         keep_o,
    output logic         last_o
);

    logic         valid_q;
    logic [W-1:0] data_q;
    logic         keep_q;
    logic         last_q;

    assign free_o = !valid_q || ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            keep_q  <= 1'b0;
            last_q  <= 1'b0;
        end else if (free_o) begin
            valid_q <= load_i;
            if (load_i) begin
                data_q <= data_i;
                keep_q <= keep_i;
                last_q <= last_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign keep_o  = keep_q;
    assign last_o  = last_q;

endmodule

// File: rtl/axis_checksum_append.sv
// Forwards every input beat unchanged and appends a two's-complement checksum beat
// after each packet. Define AXIS_CSUM_PKT_CNT_EN to add the pkt_count output.
module axis_checksum_append
    import axis_pkg::*;
#(
    parameter int data_bits = CSUM_W_DEFAULT
) (
    input  logic                 axis_clk,
    input  logic                 axis_resetn,
    input  logic [data_bits-1:0] s_axis_tdata,
    input  logic                 s_axis_tkeep,
    input  logic                 s_axis_tlast,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    output logic [data_bits-1:0] m_axis_tdata,
    output logic                 m_axis_tkeep,
    output logic                 m_axis_tlast,
    output logic                 m_axis_tvalid,
`ifdef AXIS_CSUM_PKT_CNT_EN
    output logic [15:0]          pkt_count,
`endif
    input  logic                 m_axis_tready
);

    localparam int CSUM_W = data_bits;

    csum_state_e       state_q, state_d;
    logic [CSUM_W-1:0] acc_q, acc_d;
    logic [CSUM_W-1:0] sum;
    logic              out_free;
    logic              in_fire;
    logic              ld;
    logic [CSUM_W-1:0] ld_data;
    logic              ld_keep;
    logic              ld_last;

    // Combinational from m_axis_tready: no skid buffer behind the output register.
    assign s_axis_tready = (state_q == ST_PASS) && out_free && axis_resetn;
    assign in_fire       = fire(s_axis_tvalid, s_axis_tready);
    assign sum           = s_axis_tkeep ? acc_q + s_axis_tdata : acc_q;

    always_ff @(posedge axis_clk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            state_q <= ST_PASS;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ld      = 1'b0;
        ld_data = s_axis_tdata;
        ld_keep = s_axis_tkeep;
        ld_last = 1'b0;
        case (state_q)
            ST_PASS: begin
                if (in_fire) begin
                    ld    = 1'b1;
                    acc_d = sum;
                    if (s_axis_tlast) state_d = ST_CSUM;
                end
            end
            ST_CSUM: begin
                if (out_free) begin
                    ld      = 1'b1;
                    ld_data = ~acc_q + CSUM_W'(1);
                    ld_keep = 1'b1;
                    ld_last = 1'b1;
                    acc_d   = '0;
                    state_d = ST_PASS;
                end
            end
        endcase
    end

    axis_out_reg #(.W(CSUM_W)) u_out_reg (
        .clk_i   (axis_clk),
        .rst_ni  (axis_resetn),
        .load_i  (ld),
        .data_i  (ld_data),
        .keep_i  (ld_keep),
        .last_i  (ld_last),
        .ready_i (m_axis_tready),
        .free_o  (out_free),
        .valid_o (m_axis_tvalid),
        .data_o  (m_axis_tdata),
        .keep_o  (m_axis_tkeep),
        .last_o  (m_axis_tlast)
    );

`ifdef AXIS_CSUM_PKT_CNT_EN
    logic [15:0] pkt_count_q;

    always_ff @(posedge axis_clk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            pkt_count_q <= '0;
        end else if (fire(m_axis_tvalid, m_axis_tready) && m_axis_tlast) begin
            pkt_count_q <= pkt_count_q + 16'd1;
        end
    end

    assign pkt_count = pkt_count_q;
`endif

endmodule

// File: tb/tb_axis_checksum_append.sv
// Directed bench for axis_checksum_append: hand-computed packets and checksums,
// backpressure, back-to-back packets and reset mid-packet.
module tb_axis_checksum_append;

    logic       axis_clk = 1'b0;
    logic       axis_resetn = 1'b0;
    logic [7:0] s_axis_tdata = '0;
    logic       s_axis_tkeep = 1'b0;
    logic       s_axis_tlast = 1'b0;
    logic       s_axis_tvalid = 1'b0;
    logic       s_axis_tready;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tkeep;
    logic       m_axis_tlast;
    logic       m_axis_tvalid;
    logic       m_axis_tready = 1'b0;
`ifdef AXIS_CSUM_PKT_CNT_EN
    logic [15:0] pkt_count;
    logic [15:0] cnt0;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [9:0] obs_q[$];

    axis_checksum_append #(.data_bits(8)) dut (
        .axis_clk      (axis_clk),
        .axis_resetn   (axis_resetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
`ifdef AXIS_CSUM_PKT_CNT_EN
        .pkt_count     (pkt_count),
`endif
        .m_axis_tready (m_axis_tready)
    );

    always #5 axis_clk = ~axis_clk;

    // Inputs only change just after a rising edge, so a handshake seen here completes.
    always @(negedge axis_clk) begin
        if (axis_resetn && m_axis_tvalid && m_axis_tready)
            obs_q.push_back({m_axis_tlast, m_axis_tkeep, m_axis_tdata});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_beat(input logic [7:0] d, input logic k, input logic l);
        int cyc;
        cyc = 0;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        @(negedge axis_clk);
        while (!s_axis_tready && cyc < 50) begin
            cyc++;
            @(negedge axis_clk);
        end
        if (!s_axis_tready) check("send_timeout", {31'd0, s_axis_tready}, 32'd1);
        @(posedge axis_clk);
        #1;
    endtask

    task automatic idle(input int n);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        repeat (n) @(posedge axis_clk);
        #1;
    endtask

    // exp = {tlast, tkeep, tdata}
    task automatic expect_beat(input string tag, input logic [9:0] exp);
        if (obs_q.size() == 0) check({tag, "_count"}, obs_q.size(), 32'd1);
        else check(tag, {22'd0, obs_q.pop_front()}, {22'd0, exp});
    endtask

    initial begin
        // Reset state
        m_axis_tready = 1'b1;
        repeat (2) @(posedge axis_clk);
        #1;
        check("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        check("rst_tdata",  {24'd0, m_axis_tdata}, 32'd0);
        check("rst_tkeep",  {31'd0, m_axis_tkeep}, 32'd0);
        check("rst_tlast",  {31'd0, m_axis_tlast}, 32'd0);
        check("rst_s_tready", {31'd0, s_axis_tready}, 32'd0);
        @(negedge axis_clk);
        axis_resetn = 1'b1;
        @(posedge axis_clk);
        #1;

        // 01,02,03 -> checksum FA, one-cycle latency
        send_beat(8'h01, 1'b1, 1'b0);
        check("t1_lat_valid", {31'd0, m_axis_tvalid}, 32'd1);
        check("t1_lat_data",  {24'd0, m_axis_tdata}, 32'h01);
        send_beat(8'h02, 1'b1, 1'b0);
        send_beat(8'h03, 1'b1, 1'b1);
        idle(4);
        expect_beat("t1_b0", {2'b01, 8'h01});
        expect_beat("t1_b1", {2'b01, 8'h02});
        expect_beat("t1_b2", {2'b01, 8'h03});
        expect_beat("t1_cs", {2'b11, 8'hFA});
        check("t1_extra", obs_q.size(), 32'd0);

        // tkeep=0 beat excluded from the sum
        send_beat(8'h10, 1'b0, 1'b0);
        send_beat(8'h05, 1'b1, 1'b1);
        idle(4);
        expect_beat("t2_b0", {2'b00, 8'h10});
        expect_beat("t2_b1", {2'b01, 8'h05});
        expect_beat("t2_cs", {2'b11, 8'hFB});

        // Accumulator wrap: FF+FF+03 = 01 -> FF
        send_beat(8'hFF, 1'b1, 1'b0);
        send_beat(8'hFF, 1'b1, 1'b0);
        send_beat(8'h03, 1'b1, 1'b1);
        idle(4);
        expect_beat("t3_b0", {2'b01, 8'hFF});
        expect_beat("t3_b1", {2'b01, 8'hFF});
        expect_beat("t3_b2", {2'b01, 8'h03});
        expect_beat("t3_cs", {2'b11, 8'hFF});

        // Backpressure: m_axis_tready 1,0,0,1 during packet 01,02
        m_axis_tready = 1'b1;
        s_axis_tdata = 8'h01; s_axis_tkeep = 1'b1; s_axis_tlast = 1'b0; s_axis_tvalid = 1'b1;
        @(posedge axis_clk);
        #1;
        m_axis_tready = 1'b0;
        s_axis_tdata = 8'h02; s_axis_tlast = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge axis_clk);
            check("t4_stall_s_tready", {31'd0, s_axis_tready}, 32'd0);
            check("t4_stall_valid", {31'd0, m_axis_tvalid}, 32'd1);
            check("t4_stall_data", {24'd0, m_axis_tdata}, 32'h01);
            @(posedge axis_clk);
            #1;
        end
        m_axis_tready = 1'b1;
        @(negedge axis_clk);
        check("t4_resume_s_tready", {31'd0, s_axis_tready}, 32'd1);
        @(posedge axis_clk);
        #1;
        idle(4);
        expect_beat("t4_b0", {2'b01, 8'h01});
        expect_beat("t4_b1", {2'b01, 8'h02});
        expect_beat("t4_cs", {2'b11, 8'hFD});
        check("t4_extra", obs_q.size(), 32'd0);

        // Back-to-back single-beat packets
`ifdef AXIS_CSUM_PKT_CNT_EN
        cnt0 = pkt_count;
`endif
        send_beat(8'h01, 1'b1, 1'b1);
        send_beat(8'h02, 1'b1, 1'b1);
        idle(4);
        expect_beat("t5_b0", {2'b01, 8'h01});
        expect_beat("t5_cs0", {2'b11, 8'hFF});
        expect_beat("t5_b1", {2'b01, 8'h02});
        expect_beat("t5_cs1", {2'b11, 8'hFE});
`ifdef AXIS_CSUM_PKT_CNT_EN
        check("t5_pkt_count", {16'd0, 16'(pkt_count - cnt0)}, 32'd2);
`endif

        // Reset mid-packet
        send_beat(8'h07, 1'b1, 1'b0);
        s_axis_tvalid = 1'b0;
        #2;
        axis_resetn = 1'b0;
        #1;
        check("t6_rst_valid", {31'd0, m_axis_tvalid}, 32'd0);
        check("t6_rst_data",  {24'd0, m_axis_tdata}, 32'd0);
        check("t6_rst_last",  {31'd0, m_axis_tlast}, 32'd0);
        check("t6_rst_s_tready", {31'd0, s_axis_tready}, 32'd0);
        repeat (2) @(posedge axis_clk);
        @(negedge axis_clk);
        axis_resetn = 1'b1;
        obs_q.delete();
        repeat (3) @(posedge axis_clk);
        #1;
        check("t6_no_emit", {31'd0, m_axis_tvalid}, 32'd0);
        check("t6_no_beats", obs_q.size(), 32'd0);
        send_beat(8'h01, 1'b1, 1'b1);
        idle(4);
        expect_beat("t6_b0", {2'b01, 8'h01});
        expect_beat("t6_cs", {2'b11, 8'hFF});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
